// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and helpers for the CPU front end.
//   XLEN              - architectural register / address width
//   RESET_PC_DEFAULT  - default first fetch address after reset
//   NOP_INSTR         - canonical NOP (addi x0,x0,0) driven on empty slots
//   word_align()      - clears the byte-offset bits of an address
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  // Fetch targets are silently forced onto a word boundary; there is no
  // misalignment trap in this core.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO holding {pc, instruction} pairs.
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   push_i   - write wdata_i at the tail (ignored when full and not popping)
//   pop_i    - drop the head entry (ignored when empty)
//   flush_i  - discard every entry; wins over push and pop
//   wdata_i  - entry to write
//   rdata_o  - current head entry (only meaningful when !empty_o)
//   full_o   - no free slot
//   empty_o  - no valid entry
//   count_o  - number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves on the
  // same edge, so the count simply stays put.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: the head is never observed while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding decode.
//   clk             - clock, rising edge
//   reset           - asynchronous active-low reset (0 = reset)
//   imem_req_valid  - fetch request valid (combinational, credit limited)
//   imem_req_ready  - memory accepts the request this cycle
//   imem_req_addr   - word-aligned fetch address (current fetch PC)
//   imem_rsp_valid  - in-order response valid
//   imem_rsp_data   - fetched instruction word
//   stall           - decode cannot take the presented instruction
//   redirect_valid  - taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc     - new fetch target (low two bits ignored)
//   if_valid        - presented instruction is real
//   if_pc           - PC of presented instruction (0 when invalid)
//   if_instruction  - presented instruction (NOP_INSTR when invalid)
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instruction
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS_C = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2*XLEN-1:0] fifo_wdata;
  logic [2*XLEN-1:0] fifo_rdata;

  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              rsp_take;

  // Every in-flight request reserves a FIFO slot, so a response can always
  // be pushed without back-pressuring memory.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = reset && !redirect_valid && !fifo_full &&
                          (credit_used < CREDITS_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. strays after a reset) are
  // ignored so the counters can never underflow.
  assign rsp_take   = imem_rsp_valid && (outstanding_q != '0);
  assign fifo_push  = rsp_take && (discard_q == '0) && !redirect_valid;
  assign fifo_pop   = !fifo_empty && !stall;
  assign fifo_wdata = {rsp_pc_q, imem_rsp_data};

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign if_valid       = !fifo_empty;
  assign if_pc          = fifo_empty ? '0        : fifo_rdata[2*XLEN-1:XLEN];
  assign if_instruction = fifo_empty ? NOP_INSTR : fifo_rdata[XLEN-1:0];

  // Next-state for the PCs and the in-flight bookkeeping. A redirect turns
  // every request still in flight (minus a response landing this very cycle)
  // into one to be thrown away; back-to-back redirects stay correct because
  // outstanding already covers all of them.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      discard_d  = outstanding_q - CW'(rsp_take);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_take) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 rsp_pc_d  = rsp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= word_align(RESET_PC);
      rsp_pc_q      <= word_align(RESET_PC);
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a 1-cycle in-order
// memory whose responses can be held back; memory word at address A is
// A ^ 32'hC0DE_0000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  int          checksTotal  = 0;
  int          checksPassed = 0;
  logic [31:0] pendQ[$];
  logic        memRelease;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // One clock: note an accepted request, then present the oldest pending
  // response during the following cycle if memory is releasing.
  task automatic applyStimulus();
    logic        fire;
    logic [31:0] addr;
    #1;
    fire = imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (fire) pendQ.push_back(addr);
    if (memRelease && pendQ.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pendQ.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic resetDut();
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    memRelease     = 1'b1;
    pendQ.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  // Step until if_valid (bounded), then check the presented pair.
  task automatic waitValid(input string tag, input logic [31:0] expPc, input int budget);
    for (int n = 0; n < budget && !if_valid; n++) applyStimulus();
    checkOutput({tag, "_valid"}, 32'(if_valid), 32'd1);
    checkOutput({tag, "_pc"}, if_pc, expPc);
    checkOutput({tag, "_instr"}, if_instruction, memWord(expPc));
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    memRelease     = 1'b1;
    #3;
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instruction, NOP);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // Streaming fetch from RESET_PC with a 1-cycle memory.
    $display("[TB] streaming fetch");
    resetDut();
    imem_req_ready = 1'b1;
    #1;
    checkOutput("s1_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("s1_req_addr0", imem_req_addr, 32'h0);
    applyStimulus();
    checkOutput("s1_not_yet_valid", 32'(if_valid), 32'd0);
    applyStimulus();
    checkOutput("s1_valid_lat2", 32'(if_valid), 32'd1);
    checkOutput("s1_pc0", if_pc, 32'h0);
    checkOutput("s1_instr0", if_instruction, 32'hC0DE_0000);
    checkOutput("s1_credit_limit", 32'(imem_req_valid), 32'd0);
    applyStimulus();
    checkOutput("s1_pc4", if_pc, 32'h4);
    checkOutput("s1_instr4", if_instruction, 32'hC0DE_0004);
    checkOutput("s1_req_addr8", imem_req_addr, 32'h8);
    applyStimulus();
    waitValid("s1_w8", 32'h8, 5);

    // Stall with the FIFO filling: head held, requests stop at the limit.
    $display("[TB] stall");
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1;
      #1;
      checkOutput("s2_hold_pc", if_pc, 32'h8);
      checkOutput("s2_req_blocked", 32'(imem_req_valid), 32'd0);
      applyStimulus();
    end
    stall = 1'b0;
    #1;
    checkOutput("s2_release_pc", if_pc, 32'h8);
    applyStimulus();
    checkOutput("s2_next_pc", if_pc, 32'hC);
    checkOutput("s2_next_instr", if_instruction, 32'hC0DE_000C);
    checkOutput("s2_req_addr10", imem_req_addr, 32'h10);
    applyStimulus();
    waitValid("s2_w10", 32'h10, 5);

    // Redirect with two requests in flight.
    $display("[TB] redirect with requests in flight");
    resetDut();
    memRelease     = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    checkOutput("s3_req_addr0", imem_req_addr, 32'h0);
    applyStimulus();
    checkOutput("s3_req_addr4", imem_req_addr, 32'h4);
    applyStimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    memRelease     = 1'b1;
    #1;
    checkOutput("s3_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("s3_discard_blocks_req", 32'(imem_req_valid), 32'd0);
    checkOutput("s3_drop0", 32'(if_valid), 32'd0);
    applyStimulus();
    checkOutput("s3_req_valid_target", 32'(imem_req_valid), 32'd1);
    checkOutput("s3_req_addr_target", imem_req_addr, 32'h100);
    applyStimulus();
    checkOutput("s3_drop4", 32'(if_valid), 32'd0);
    applyStimulus();
    checkOutput("s3_valid_target", 32'(if_valid), 32'd1);
    checkOutput("s3_pc_target", if_pc, 32'h100);
    checkOutput("s3_instr_target", if_instruction, 32'hC0DE_0100);

    // Redirect together with stall and a response landing the same cycle.
    $display("[TB] redirect with stall and response");
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    checkOutput("s4_rsp_present", 32'(imem_rsp_valid), 32'd1);
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("s4_flushed_valid", 32'(if_valid), 32'd0);
    checkOutput("s4_flushed_pc", if_pc, 32'h0);
    checkOutput("s4_flushed_instr", if_instruction, NOP);
    checkOutput("s4_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("s4_req_addr", imem_req_addr, 32'h40);
    applyStimulus();
    applyStimulus();
    checkOutput("s4_valid", 32'(if_valid), 32'd1);
    checkOutput("s4_pc", if_pc, 32'h40);
    checkOutput("s4_instr", if_instruction, 32'hC0DE_0040);

    // Misaligned redirect target.
    $display("[TB] misaligned redirect");
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("s5_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("s5_req_addr", imem_req_addr, 32'h200);
    checkOutput("s5_flushed", 32'(if_valid), 32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("s5_pc", if_pc, 32'h200);
    checkOutput("s5_instr", if_instruction, 32'hC0DE_0200);

    // Asynchronous reset mid-operation, then a stray response.
    $display("[TB] reset mid-operation");
    stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("s6_rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("s6_rst_if_pc", if_pc, 32'h0);
    checkOutput("s6_rst_if_instr", if_instruction, NOP);
    checkOutput("s6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    pendQ.delete();
    reset          = 1'b1;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    checkOutput("s6_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("s6_req_addr", imem_req_addr, 32'h0);
    applyStimulus();
    checkOutput("s6_stray_ignored", 32'(if_valid), 32'd0);
    checkOutput("s6_req_valid_after_stray", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    #1;
    applyStimulus();
    applyStimulus();
    checkOutput("s6_valid", 32'(if_valid), 32'd1);
    checkOutput("s6_pc", if_pc, 32'h0);
    checkOutput("s6_instr", if_instruction, 32'hC0DE_0000);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
